// File: rtl/snn_mem_loader.sv
// SPI mode-0 slave that streams a command/address header followed by data words
// into the SNN parameter memory write port, with auto-incrementing, wrapping address.
module snn_mem_loader #(
  parameter int M  = 320,
  parameter int N  = 8,
  parameter int AW = $clog2(M)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          spi_sclk,
  input  logic          spi_mosi,
  input  logic          spi_cs_n,
  output logic [AW-1:0] mem_addr,
  output logic [N-1:0]  mem_data,
  output logic          mem_we,
  output logic          busy,
  output logic          loaded,
  output logic          addr_err
);

  localparam int SW = (N > 8) ? N : 8;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    IGNORE
  } state_t;

  state_t          state_q, state_d;
  logic            armed_q, armed_d;
  logic [7:0]      hi_q, hi_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [SW-2:0]   shift_q, shift_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [N-1:0]    mem_data_q, mem_data_d;
  logic            loaded_q, loaded_d;
  logic            addr_err_q, addr_err_d;

  logic sclk_s1_q, sclk_s2_q, sclk_h_q;
  logic mosi_s1_q, mosi_s2_q, mosi_h_q;
  logic cs_s1_q, cs_s2_q, cs_h_q;

  logic            sclk_rise;
  logic            cs_high;
  logic [SW-1:0]   shifted;
  logic [CW-1:0]   cnt_inc;
  logic [CW-1:0]   field_len;
  logic            field_done;
  logic [15:0]     addr16;

  // mosi and cs_n are taken from the history stage so their age matches the sclk edge detector
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_s1_q <= 1'b0;
      sclk_s2_q <= 1'b0;
      sclk_h_q  <= 1'b0;
      mosi_s1_q <= 1'b0;
      mosi_s2_q <= 1'b0;
      mosi_h_q  <= 1'b0;
      cs_s1_q   <= 1'b0;
      cs_s2_q   <= 1'b0;
      cs_h_q    <= 1'b0;
    end else begin
      sclk_s1_q <= spi_sclk;
      sclk_s2_q <= sclk_s1_q;
      sclk_h_q  <= sclk_s2_q;
      mosi_s1_q <= spi_mosi;
      mosi_s2_q <= mosi_s1_q;
      mosi_h_q  <= mosi_s2_q;
      cs_s1_q   <= spi_cs_n;
      cs_s2_q   <= cs_s1_q;
      cs_h_q    <= cs_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      armed_q    <= 1'b0;
      hi_q       <= '0;
      ptr_q      <= '0;
      shift_q    <= '0;
      cnt_q      <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      loaded_q   <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      hi_q       <= hi_d;
      ptr_q      <= ptr_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      loaded_q   <= loaded_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    hi_d       = hi_q;
    ptr_d      = ptr_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    loaded_d   = loaded_q;
    addr_err_d = addr_err_q;

    sclk_rise  = sclk_s2_q & ~sclk_h_q;
    cs_high    = cs_h_q;
    shifted    = {shift_q, mosi_h_q};
    cnt_inc    = cnt_q + 1'b1;
    field_len  = (state_q == DATA) ? CW'(N) : CW'(8);
    field_done = sclk_rise && (cnt_inc == field_len);
    addr16     = {hi_q, shifted[7:0]};

    // After reset a frame is only accepted once cs_n has been seen high
    if (cs_high) begin
      armed_d = 1'b1;
    end

    if (state_q != IDLE && sclk_rise) begin
      shift_d = shifted[SW-2:0];
      cnt_d   = field_done ? '0 : cnt_inc;
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (armed_q && !cs_high) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (field_done) begin
          state_d = (shifted[7:0] == 8'h01) ? ADDR_HI : IGNORE;
        end
      end
      ADDR_HI: begin
        if (field_done) begin
          hi_d    = shifted[7:0];
          state_d = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (field_done) begin
          if (addr16 < 16'(M)) begin
            ptr_d   = addr16[AW-1:0];
            state_d = DATA;
          end else begin
            addr_err_d = 1'b1;
            state_d    = IGNORE;
          end
        end
      end
      DATA: begin
        if (field_done) begin
          mem_we_d   = 1'b1;
          mem_addr_d = ptr_q;
          mem_data_d = shifted[N-1:0];
          if (ptr_q == AW'(M - 1)) begin
            loaded_d = 1'b1;
            ptr_d    = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      IGNORE: begin
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A word completing in the same cycle as cs_n rising is still written above
    if (cs_high) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign busy     = armed_q & ~cs_high;
  assign loaded   = loaded_q;
  assign addr_err = addr_err_q;

endmodule

// File: tb/tb_snn_mem_loader.sv
// Self-checking bench for snn_mem_loader: directed frames plus random frames,
// checked against a frame-level model of the expected memory writes.
`timescale 1ns/1ps
module tb_snn_mem_loader;

   localparam int M  = 320;
   localparam int N  = 8;
   localparam int AW = 9;
   localparam int H  = 50;

   logic          clk;
   logic          rst_n;
   logic          spi_sclk;
   logic          spi_mosi;
   logic          spi_cs_n;
   logic [AW-1:0] mem_addr;
   logic [N-1:0]  mem_data;
   logic          mem_we;
   logic          busy;
   logic          loaded;
   logic          addr_err;

   typedef struct {
      int addr;
      int data;
      bit loadedAfter;
   } wr_t;

   wr_t        expQ[$];
   wr_t        monEntry;
   int         checks;
   int         errors;
   bit         mdlLoaded;
   bit         mdlErr;
   bit         prevWe;
   logic [7:0] frameBytes[$];
   int         tailBits;
   logic [7:0] tailVal;
   bit         csAtLastRise;

   snn_mem_loader #(.M(M), .N(N), .AW(AW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .spi_sclk (spi_sclk),
      .spi_mosi (spi_mosi),
      .spi_cs_n (spi_cs_n),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .mem_we   (mem_we),
      .busy     (busy),
      .loaded   (loaded),
      .addr_err (addr_err)
   );

   // 100 MHz system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
      end
   endtask

   // Write monitor: every mem_we pulse must match the next expected write and last one cycle
   always @(negedge clk) begin
      if (prevWe) begin
         checkOutput("we_width", {31'b0, mem_we}, 32'd0);
      end
      if (mem_we === 1'b1 && !prevWe) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpected_we", {31'b0, mem_we}, 32'd0);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("we_addr", {23'b0, mem_addr}, monEntry.addr);
            checkOutput("we_data", {24'b0, mem_data}, monEntry.data);
            checkOutput("loaded_at_we", {31'b0, loaded}, {31'b0, monEntry.loadedAfter});
         end
      end
      prevWe = (mem_we === 1'b1);
   end

   // Frame-level reference: which words land where, and what the sticky flags become
   task automatic modelFrame();
      int ptr;
      if (frameBytes.size() < 3) return;
      if (frameBytes[0] != 8'h01) return;
      ptr = {frameBytes[1], frameBytes[2]};
      if (ptr >= M) begin
         mdlErr = 1'b1;
         return;
      end
      for (int i = 3; i < frameBytes.size(); i++) begin
         if (ptr == M - 1) mdlLoaded = 1'b1;
         expQ.push_back('{addr: ptr, data: frameBytes[i], loadedAfter: mdlLoaded});
         ptr = (ptr + 1) % M;
      end
   endtask

   // Mode 0: mosi changes while sclk is low, sampled on the rising edge
   task automatic spiBit(input logic b);
      spi_mosi = b;
      #H spi_sclk = 1'b1;
      #H spi_sclk = 1'b0;
   endtask

   task automatic spiBits(input logic [7:0] v, input int nbits);
      for (int i = 7; i > 7 - nbits; i--) spiBit(v[i]);
   endtask

   // Send one frame from frameBytes/tailBits, then check flags and write count
   task automatic applyStimulus();
      logic [7:0] lastByte;
      modelFrame();
      spi_cs_n = 1'b0;
      #H;
      for (int k = 0; k < frameBytes.size(); k++) begin
         if (csAtLastRise && k == frameBytes.size() - 1) begin
            lastByte = frameBytes[k];
            spiBits(lastByte, 7);
            spi_mosi = lastByte[0];
            #H;
            spi_sclk = 1'b1;
            spi_cs_n = 1'b1;
            #H spi_sclk = 1'b0;
         end else begin
            spiBits(frameBytes[k], 8);
         end
         if (k == 0) checkOutput("busy_in_frame", {31'b0, busy}, 32'd1);
      end
      if (tailBits > 0) spiBits(tailVal, tailBits);
      #H spi_cs_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      checkOutput("pending_writes", expQ.size(), 32'd0);
      checkOutput("loaded", {31'b0, loaded}, {31'b0, mdlLoaded});
      checkOutput("addr_err", {31'b0, addr_err}, {31'b0, mdlErr});
      checkOutput("busy_idle", {31'b0, busy}, 32'd0);
      expQ.delete();
      tailBits     = 0;
      csAtLastRise = 1'b0;
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_we"},       {31'b0, mem_we},   32'd0);
      checkOutput({tag, "_addr"},     {23'b0, mem_addr}, 32'd0);
      checkOutput({tag, "_data"},     {24'b0, mem_data}, 32'd0);
      checkOutput({tag, "_busy"},     {31'b0, busy},     32'd0);
      checkOutput({tag, "_loaded"},   {31'b0, loaded},   32'd0);
      checkOutput({tag, "_addr_err"}, {31'b0, addr_err}, 32'd0);
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int addr;
      int cnt;
      int kind;
      logic [7:0] b;
      checks = 0;
      errors = 0;
      mdlLoaded = 1'b0;
      mdlErr = 1'b0;
      prevWe = 1'b0;
      tailBits = 0;
      tailVal = 8'h00;
      csAtLastRise = 1'b0;
      rst_n = 1'b0;
      spi_sclk = 1'b0;
      spi_mosi = 1'b0;
      spi_cs_n = 1'b1;
      #22;
      checkAllZero("reset");
      #11 rst_n = 1'b1;
      repeat (10) @(posedge clk);

      $display("[TB] test 1: basic write");
      frameBytes = '{8'h01, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
      applyStimulus();

      $display("[TB] test 2: wrap at end of memory");
      frameBytes = '{8'h01, 8'h01, 8'h3E, 8'hAA, 8'hBB, 8'hCC};
      applyStimulus();

      $display("[TB] test 3: start address out of range");
      frameBytes = '{8'h01, 8'h01, 8'h40, 8'h55};
      applyStimulus();

      $display("[TB] test 4: unknown command");
      frameBytes = '{8'h7F, 8'h01, 8'h00, 8'h05, 8'h66};
      applyStimulus();

      $display("[TB] test 5: partial word discarded");
      frameBytes = '{8'h01, 8'h00, 8'h0A, 8'h12};
      tailBits = 5;
      tailVal = 8'h34;
      applyStimulus();
      frameBytes = '{8'h01, 8'h00, 8'h14, 8'h9A};
      applyStimulus();

      $display("[TB] test 6: reset mid data word");
      spi_cs_n = 1'b0;
      #H;
      spiBits(8'h01, 8);
      spiBits(8'h00, 8);
      spiBits(8'h28, 8);
      spiBits(8'hF0, 4);
      #3 rst_n = 1'b0;
      #1;
      checkAllZero("async_reset");
      expQ.delete();
      mdlLoaded = 1'b0;
      mdlErr = 1'b0;
      spi_cs_n = 1'b1;
      spi_sclk = 1'b0;
      #40 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checkAllZero("after_reset");
      frameBytes = '{8'h01, 8'h00, 8'h02, 8'h77};
      applyStimulus();

      $display("[TB] random frames");
      for (int f = 0; f < 25; f++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0, 3: addr = $urandom_range(0, M - 1);
            1: addr = $urandom_range(M - 4, M - 1);
            default: addr = $urandom_range(M, 65535);
         endcase
         frameBytes.delete();
         if ($urandom_range(0, 7) == 0) begin
            b = 8'($urandom_range(0, 255));
            if (b == 8'h01) b = 8'h02;
            frameBytes.push_back(b);
         end else begin
            frameBytes.push_back(8'h01);
         end
         frameBytes.push_back(8'(addr >> 8));
         frameBytes.push_back(8'(addr));
         cnt = $urandom_range(0, 6);
         for (int i = 0; i < cnt; i++) frameBytes.push_back(8'($urandom_range(0, 255)));
         tailBits = $urandom_range(0, 7);
         tailVal = 8'($urandom_range(0, 255));
         csAtLastRise = (tailBits == 0 && cnt > 0 && $urandom_range(0, 1) == 1);
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
